// File: rtl/regdump_scanner_if.sv
// Word stream from the register-dump scanner to its consumer (valid/ready).
interface regdump_scanner_if;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_index;
  logic [31:0] out_data;

  modport master (
    output out_valid,
    output out_index,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_index,
    input  out_data,
    output out_ready
  );
endinterface

// File: rtl/regdump_scanner.sv
// Walks the debug register select FIRST_REG..LAST_REG and streams each value; REGDUMP_PC_CAPTURE_EN appends the start-time PC as index 32.
// First word SETTLE_CYCLES+1 cycles after start, then one per SETTLE_CYCLES+1; a word holds stable while out_ready is low.
module regdump_scanner #(
  parameter int FIRST_REG     = 0,
  parameter int LAST_REG      = 31,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [31:0]       RegOut,
  input  logic [31:0]       PCout,
  output logic [4:0]        Input_Readreg,
  output logic              Input_ReadPC,
  output logic              busy,
  output logic              done,
  regdump_scanner_if.master out_if
);

  typedef enum logic [1:0] {IDLE, SETTLE, PRESENT, FINISH} state_t;

  localparam logic [5:0] PC_IDX = 6'd32;

  state_t      state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [4:0]  readreg_q, readreg_d;
  logic        vld_q, vld_d;
  logic [5:0]  oidx_q, oidx_d;
  logic [31:0] odat_q, odat_d;
  logic        xfer;

`ifdef REGDUMP_PC_CAPTURE_EN
  logic [31:0] pc_q, pc_d;
`endif

  assign xfer = vld_q && out_if.out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      readreg_q <= '0;
      vld_q     <= 1'b0;
      oidx_q    <= '0;
      odat_q    <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      readreg_q <= readreg_d;
      vld_q     <= vld_d;
      oidx_q    <= oidx_d;
      odat_q    <= odat_d;
    end
  end

`ifdef REGDUMP_PC_CAPTURE_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    readreg_d = readreg_q;
    vld_d     = vld_q;
    oidx_d    = oidx_q;
    odat_d    = odat_q;
`ifdef REGDUMP_PC_CAPTURE_EN
    pc_d      = pc_q;
`endif
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          idx_d     = 6'(FIRST_REG);
          readreg_d = 5'(FIRST_REG);
          cnt_d     = 4'(SETTLE_CYCLES);
          state_d   = SETTLE;
`ifdef REGDUMP_PC_CAPTURE_EN
          pc_d      = PCout;
`endif
        end
      end
      SETTLE: begin
        cnt_d = 4'(cnt_q - 4'd1);
        if (cnt_q <= 4'd1) begin
          odat_d  = RegOut;
          oidx_d  = idx_q;
          vld_d   = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (xfer) begin
          vld_d = 1'b0;
          if (idx_q < 6'(LAST_REG)) begin
            idx_d     = 6'(idx_q + 6'd1);
            readreg_d = 5'(idx_q[4:0] + 5'd1);
            cnt_d     = 4'(SETTLE_CYCLES);
            state_d   = SETTLE;
          end
`ifdef REGDUMP_PC_CAPTURE_EN
          // The PC word follows the last register back-to-back, no settle needed.
          else if (idx_q != PC_IDX) begin
            idx_d  = PC_IDX;
            oidx_d = PC_IDX;
            odat_d = pc_q;
            vld_d  = 1'b1;
          end
`endif
          else begin
            state_d = FINISH;
          end
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort overrides everything, including a word transferring this cycle.
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      vld_d   = 1'b0;
    end
  end

`ifdef REGDUMP_PC_CAPTURE_EN
  assign Input_ReadPC = (state_q == PRESENT) && (idx_q == PC_IDX);
`else
  logic unused_pcout;
  assign unused_pcout = ^PCout;
  assign Input_ReadPC = 1'b0;
`endif

  assign Input_Readreg    = readreg_q;
  assign busy             = (state_q != IDLE);
  assign done             = (state_q == FINISH);
  assign out_if.out_valid = vld_q;
  assign out_if.out_index = oidx_q;
  assign out_if.out_data  = odat_q;

endmodule
